// File: rtl/stream_write_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stream_write_buffer_pkg
// Description : Shared types and helpers for the stream write buffer slice.
//               Burst FSM state encoding, descriptor length width and the
//               FIFO occupancy-count width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package stream_write_buffer_pkg;

    // Burst FSM states. The encoding values are fixed so they can be
    // matched against waveforms and debug probes.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } burst_state_t;

    // Internal burst length register width. A full burst can be 256 beats,
    // which needs 9 bits before the AXI beats-1 encoding is applied.
    localparam int c_len_w = 9;

    // AXI burst length field width (beats-1 encoding).
    localparam int c_axi_len_w = 8;

    // Occupancy count must represent 0..DEPTH inclusive, so it needs one bit
    // more than the pointer width.
    function automatic int count_width(input int addr_w);
        return addr_w + 1;
    endfunction

endpackage : stream_write_buffer_pkg
`default_nettype wire

// File: rtl/stream_write_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : stream_write_buffer_if
// Description : AXI-style write path between the stream write buffer
//               (master) and the downstream AXI write engine (slave).
//               Carries the burst descriptor channel and the beat channel.
// Revision    : 1.0 - initial release
// ============================================================================
interface stream_write_buffer_if #(
    parameter int AXI_DATA_W = 64
);

    // Burst descriptor channel
    logic                  wr_burst_valid;
    logic                  wr_burst_ready;
    logic [7:0]            wr_burst_len;

    // Beat channel
    logic                  wr_data_valid;
    logic                  wr_data_ready;
    logic [AXI_DATA_W-1:0] wr_data;
    logic                  wr_data_last;

    modport master (
        output wr_burst_valid,
        output wr_burst_len,
        input  wr_burst_ready,
        output wr_data_valid,
        output wr_data,
        output wr_data_last,
        input  wr_data_ready
    );

    modport slave (
        input  wr_burst_valid,
        input  wr_burst_len,
        output wr_burst_ready,
        input  wr_data_valid,
        input  wr_data,
        input  wr_data_last,
        output wr_data_ready
    );

endinterface : stream_write_buffer_if
`default_nettype wire

// File: rtl/stream_write_buffer_fifo.sv
`default_nettype none
// ============================================================================
// Module      : stream_fifo
// Description : Register-array first-word-fall-through FIFO with occupancy
//               count. The head word is presented combinationally from the
//               read pointer; pushes to a full FIFO and pops from an empty
//               FIFO are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_fifo
    import stream_write_buffer_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
) (
    input  wire logic                            clk,
    input  wire logic                            reset,
    input  wire logic                            i_push,
    input  wire logic [DATA_W-1:0]               i_push_data,
    input  wire logic                            i_pop,
    output logic      [DATA_W-1:0]               o_head_data,
    output logic      [count_width(ADDR_W)-1:0]  o_count,
    output logic                                 o_full,
    output logic                                 o_empty
);

    localparam int c_depth = 2 ** ADDR_W;
    localparam int c_cnt_w = count_width(ADDR_W);

    logic [DATA_W-1:0]  r_mem [c_depth];
    logic [ADDR_W-1:0]  r_wr_ptr;
    logic [ADDR_W-1:0]  r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;

    logic w_push_ok;
    logic w_pop_ok;

    assign o_full      = (r_count == c_cnt_w'(c_depth));
    assign o_empty     = (r_count == '0);
    assign w_push_ok   = i_push && !o_full;
    assign w_pop_ok    = i_pop && !o_empty;
    assign o_head_data = r_mem[r_rd_ptr];
    assign o_count     = r_count;

    // Storage write; the array holds no reset so it maps to plain flops.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Occupancy: a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else begin
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : stream_fifo
`default_nettype wire

// File: rtl/stream_write_buffer.sv
`default_nettype none
// ============================================================================
// Module      : stream_write_buffer
// Description : Absorbs the loopback stage's req/data write stream into a
//               FIFO and drains it onto the AXI write path as fixed-length
//               bursts. A flush drains any residue as one short burst.
//               stream_write_ready falls early enough to absorb the
//               producer's in-flight reqs.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_write_buffer
    import stream_write_buffer_pkg::*;
#(
    parameter int AXI_DATA_W  = 64,
    parameter int FIFO_ADDR_W = 5,
    parameter int BURST_LEN   = 16,
    parameter int READY_SLACK = 2
) (
    input  wire logic                  clk,
    input  wire logic                  reset,

    // Stream write side (producer)
    output logic                       stream_write_ready,
    input  wire logic                  stream_write_req,
    input  wire logic [AXI_DATA_W-1:0] stream_write_data,

    // Flush control and status
    input  wire logic                  flush,
    output logic                       flush_done,
    output logic                       overflow,

    // AXI write path
    stream_write_buffer_if.master      wr_bus
);

    localparam int c_depth = 2 ** FIFO_ADDR_W;
    localparam int c_cnt_w = count_width(FIFO_ADDR_W);

    // FIFO status
    logic [c_cnt_w-1:0]    w_count;
    logic [AXI_DATA_W-1:0] w_head;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_pop;

    // Burst FSM
    burst_state_t          r_state;
    burst_state_t          w_state_next;
    logic [c_len_w-1:0]    r_len;
    logic [c_len_w-1:0]    w_len_next;
    logic [c_len_w-1:0]    r_beat;
    logic [c_len_w-1:0]    w_beat_next;
    logic                  w_full_burst;
    logic                  w_last;

    logic                  r_overflow;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    stream_fifo #(
        .DATA_W (AXI_DATA_W),
        .ADDR_W (FIFO_ADDR_W)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (stream_write_req),
        .i_push_data (stream_write_data),
        .i_pop       (w_pop),
        .o_head_data (w_head),
        .o_count     (w_count),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    // ------------------------------------------------------------------
    // Producer flow control
    // ------------------------------------------------------------------
    // Ready drops while READY_SLACK entries are still free so the reqs
    // already in the producer's pipeline still find space.
    assign stream_write_ready = !reset &&
        ((c_cnt_w'(c_depth) - w_count) > c_cnt_w'(READY_SLACK));

    // Sticky overflow: a push landed on a full FIFO and the word was lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (stream_write_req && w_full) begin
            r_overflow <= 1'b1;
        end
    end

    assign overflow = r_overflow;

    // ------------------------------------------------------------------
    // Burst FSM
    // ------------------------------------------------------------------
    assign w_full_burst = (w_count >= c_cnt_w'(BURST_LEN));
    assign w_last       = (r_state == ST_DATA) && (r_beat == (r_len - c_len_w'(1)));
    assign w_pop        = (r_state == ST_DATA) && wr_bus.wr_data_ready;

    // State, latched length and beat counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_len   <= '0;
            r_beat  <= '0;
        end else begin
            r_state <= w_state_next;
            r_len   <= w_len_next;
            r_beat  <= w_beat_next;
        end
    end

    // Next-state logic: full bursts win over flush; a flush burst takes
    // the whole residue, which is always shorter than BURST_LEN here.
    always_comb begin
        w_state_next = r_state;
        w_len_next   = r_len;
        w_beat_next  = r_beat;
        case (r_state)
            ST_IDLE: begin
                if (w_full_burst) begin
                    w_state_next = ST_ADDR;
                    w_len_next   = c_len_w'(BURST_LEN);
                    w_beat_next  = '0;
                end else if (flush && !w_empty) begin
                    w_state_next = ST_ADDR;
                    w_len_next   = c_len_w'(w_count);
                    w_beat_next  = '0;
                end
            end
            ST_ADDR: begin
                if (wr_bus.wr_burst_ready) begin
                    w_state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_pop) begin
                    if (w_last) begin
                        w_state_next = ST_IDLE;
                    end else begin
                        w_beat_next = r_beat + c_len_w'(1);
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // AXI write path outputs
    // ------------------------------------------------------------------
    assign wr_bus.wr_burst_valid = (r_state == ST_ADDR);
    assign wr_bus.wr_burst_len   = (r_state == ST_ADDR) ?
                                   c_axi_len_w'(r_len - c_len_w'(1)) : '0;
    assign wr_bus.wr_data_valid  = (r_state == ST_DATA);
    assign wr_bus.wr_data_last   = w_last;
    assign wr_bus.wr_data        = w_head;

    assign flush_done = !reset && flush && (r_state == ST_IDLE) && w_empty;

endmodule : stream_write_buffer
`default_nettype wire
